// File: rtl/osc_sequencer.sv
// osc_sequencer: note/mode sequencer driving the waveshaper period counter, divisor and mode.
module osc_sequencer #(
  parameter int          NUM_MODES = 4,
  parameter logic [18:0] MIN_DIV   = 19'd2
) (
  input  logic        clk,
  input  logic        Rst_i,
  input  logic        note_valid_i,
  output logic        note_ready_o,
  input  logic [18:0] divisor_i,
  input  logic        note_off_i,
  input  logic        mode_btn_i,
  output logic [18:0] count_o,
  output logic [18:0] divisor_o,
  output logic [2:0]  mode_o,
  output logic        active_o,
  output logic        wrap_o,
  output logic        err_o
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state, state_n;
  logic        pend_valid, pend_valid_n, stop_pend, stop_pend_n, mode_pend, mode_pend_n;
  logic [18:0] pend_div, pend_div_n, count_n, div_n;
  logic [2:0]  mode_n, mode_adv;
  logic        accept, good, stop, err_n;
  assign note_ready_o = !pend_valid;
  assign active_o     = state == RUN;
  assign wrap_o       = active_o && count_o == divisor_o - 19'd1;
  assign accept       = note_valid_i && note_ready_o;
  assign good         = accept && divisor_i >= MIN_DIV;
  assign mode_adv     = mode_o == 3'(NUM_MODES - 1) ? 3'd0 : mode_o + 3'd1;
  // A note accepted on the wrap cycle cancels a pending stop at that same wrap.
  assign stop         = wrap_o && stop_pend && !good;
  always_comb begin
    state_n      = state;
    count_n      = count_o;
    div_n        = divisor_o;
    mode_n       = mode_o;
    pend_valid_n = pend_valid;
    pend_div_n   = pend_div;
    stop_pend_n  = stop_pend;
    mode_pend_n  = mode_pend;
    err_n        = accept && divisor_i < MIN_DIV;
    if (state == IDLE) begin
      mode_n      = (mode_btn_i || mode_pend) ? mode_adv : mode_o;
      mode_pend_n = 1'b0;
      stop_pend_n = 1'b0;
      if (good) begin
        state_n = RUN;
        count_n = '0;
        div_n   = divisor_i;
      end
    end else begin
      count_n = wrap_o ? '0 : count_o + 19'd1;
      if (stop) begin
        state_n      = IDLE;
        div_n        = '0;
        pend_valid_n = 1'b0;
        stop_pend_n  = 1'b0;
      end else if (wrap_o && pend_valid) begin
        div_n        = pend_div;
        pend_valid_n = 1'b0;
      end
      if (wrap_o && mode_pend) begin
        mode_n      = mode_adv;
        mode_pend_n = 1'b0;
      end
      if (mode_btn_i) mode_pend_n = 1'b1;
      if (note_off_i && !stop) stop_pend_n = 1'b1;
      if (good) begin
        pend_div_n   = divisor_i;
        pend_valid_n = 1'b1;
        stop_pend_n  = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (Rst_i) begin
      state      <= IDLE;
      count_o    <= '0;
      divisor_o  <= '0;
      mode_o     <= '0;
      err_o      <= 1'b0;
      pend_valid <= 1'b0;
      pend_div   <= '0;
      stop_pend  <= 1'b0;
      mode_pend  <= 1'b0;
    end else begin
      state      <= state_n;
      count_o    <= count_n;
      divisor_o  <= div_n;
      mode_o     <= mode_n;
      err_o      <= err_n;
      pend_valid <= pend_valid_n;
      pend_div   <= pend_div_n;
      stop_pend  <= stop_pend_n;
      mode_pend  <= mode_pend_n;
    end
  end
endmodule

// File: tb/tb_osc_sequencer.sv
// tb_osc_sequencer: directed self-checking bench for osc_sequencer.
module tb_osc_sequencer;
  logic        clk = 0, Rst_i = 1, note_valid_i = 0, note_off_i = 0, mode_btn_i = 0;
  logic [18:0] divisor_i = '0;
  logic        note_ready_o, active_o, wrap_o, err_o;
  logic [18:0] count_o, divisor_o;
  logic [2:0]  mode_o;
  int n_chk = 0, n_err = 0;
  osc_sequencer dut (
    .clk(clk), .Rst_i(Rst_i), .note_valid_i(note_valid_i), .note_ready_o(note_ready_o),
    .divisor_i(divisor_i), .note_off_i(note_off_i), .mode_btn_i(mode_btn_i),
    .count_o(count_o), .divisor_o(divisor_o), .mode_o(mode_o),
    .active_o(active_o), .wrap_o(wrap_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_for(input logic [18:0] c, input logic [18:0] d);
    for (int i = 0; i < 400 && !(count_o == c && divisor_o == d && active_o); i++) step();
    chk("wait_for", 32'(count_o == c && divisor_o == d && active_o), 1);
  endtask
  task automatic request(input logic [18:0] d);
    note_valid_i = 1;
    divisor_i = d;
    step();
    note_valid_i = 0;
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_count"}, 32'(count_o), 0);
    chk({tag, "_div"}, 32'(divisor_o), 0);
    chk({tag, "_mode"}, 32'(mode_o), 0);
    chk({tag, "_active"}, 32'(active_o), 0);
    chk({tag, "_wrap"}, 32'(wrap_o), 0);
    chk({tag, "_err"}, 32'(err_o), 0);
    chk({tag, "_ready"}, 32'(note_ready_o), 1);
  endtask
  initial begin
    step();
    step();
    check_reset("rst");
    Rst_i = 0;
    step();
    // divisor 5 from idle
    request(19'd5);
    chk("d5_active", 32'(active_o), 1);
    chk("d5_div", 32'(divisor_o), 5);
    for (int k = 0; k < 12; k++) begin
      chk("d5_count", 32'(count_o), 32'(k % 5));
      chk("d5_wrap", 32'(wrap_o), 32'(k % 5 == 4));
      step();
    end
    // divisor 3 requested mid-period goes pending
    wait_for(19'd1, 19'd5);
    request(19'd3);
    chk("p3_ready_c2", 32'(note_ready_o), 0);
    step();
    chk("p3_ready_c3", 32'(note_ready_o), 0);
    step();
    chk("p3_wrap", 32'(wrap_o), 1);
    chk("p3_div_old", 32'(divisor_o), 5);
    step();
    chk("p3_div_new", 32'(divisor_o), 3);
    chk("p3_ready_back", 32'(note_ready_o), 1);
    for (int k = 0; k < 9; k++) begin
      chk("d3_count", 32'(count_o), 32'(k % 3));
      step();
    end
    // undersized divisor dropped
    wait_for(19'd0, 19'd3);
    request(19'd1);
    chk("err_pulse", 32'(err_o), 1);
    chk("err_div", 32'(divisor_o), 3);
    chk("err_count", 32'(count_o), 1);
    chk("err_ready", 32'(note_ready_o), 1);
    step();
    chk("err_clear", 32'(err_o), 0);
    // divisor 2 accepted on the wrap cycle: pending, not applied at that wrap
    chk("d2_at_wrap", 32'(wrap_o), 1);
    request(19'd2);
    chk("d2_count0", 32'(count_o), 0);
    chk("d2_div_still3", 32'(divisor_o), 3);
    chk("d2_ready", 32'(note_ready_o), 0);
    step();
    step();
    chk("d2_wrap3", 32'(wrap_o), 1);
    step();
    chk("d2_div", 32'(divisor_o), 2);
    for (int k = 0; k < 6; k++) begin
      chk("d2_count", 32'(count_o), 32'(k % 2));
      chk("d2_wrap", 32'(wrap_o), 32'(k % 2));
      step();
    end
    // mode presses during run collapse into one advance at the wrap
    request(19'd7);
    wait_for(19'd2, 19'd7);
    chk("m_before", 32'(mode_o), 0);
    mode_btn_i = 1;
    step();
    mode_btn_i = 0;
    step();
    chk("m_c4", 32'(count_o), 4);
    mode_btn_i = 1;
    step();
    mode_btn_i = 0;
    chk("m_c5_mode", 32'(mode_o), 0);
    step();
    chk("m_wrap", 32'(wrap_o), 1);
    chk("m_wrap_mode", 32'(mode_o), 0);
    step();
    chk("m_after_count", 32'(count_o), 0);
    chk("m_after_mode", 32'(mode_o), 1);
    repeat (7) step();
    chk("m_next_count", 32'(count_o), 0);
    chk("m_next_mode", 32'(mode_o), 1);
    // note_off at count 3 of divisor 6
    request(19'd6);
    wait_for(19'd3, 19'd6);
    note_off_i = 1;
    step();
    note_off_i = 0;
    chk("off_c4_active", 32'(active_o), 1);
    step();
    chk("off_c5", 32'(count_o), 5);
    chk("off_wrap", 32'(wrap_o), 1);
    step();
    chk("off_active", 32'(active_o), 0);
    chk("off_count", 32'(count_o), 0);
    chk("off_div", 32'(divisor_o), 0);
    chk("off_wrap_low", 32'(wrap_o), 0);
    // mode presses in idle apply on the next edge: 1 -> 2,3,0,1
    mode_btn_i = 1;
    step();
    chk("idle_m2", 32'(mode_o), 2);
    step();
    chk("idle_m3", 32'(mode_o), 3);
    step();
    chk("idle_m0", 32'(mode_o), 0);
    step();
    chk("idle_m1", 32'(mode_o), 1);
    mode_btn_i = 0;
    step();
    chk("idle_hold", 32'(mode_o), 1);
    // note_off in idle ignored; note_off with a good request keeps running
    note_off_i = 1;
    request(19'd4);
    note_off_i = 0;
    chk("idle_start_active", 32'(active_o), 1);
    wait_for(19'd1, 19'd4);
    note_off_i = 1;
    request(19'd6);
    note_off_i = 0;
    step();
    chk("both_wrap", 32'(wrap_o), 1);
    step();
    chk("both_active", 32'(active_o), 1);
    chk("both_div", 32'(divisor_o), 6);
    repeat (6) step();
    chk("both_still_active", 32'(active_o), 1);
    chk("both_count", 32'(count_o), 0);
    // reset mid-period with a pending note
    request(19'd152890);
    wait_for(19'd100, 19'd152890);
    request(19'd9);
    chk("pre_rst_ready", 32'(note_ready_o), 0);
    Rst_i = 1;
    step();
    check_reset("midrst");
    Rst_i = 0;
    repeat (3) step();
    chk("post_rst_active", 32'(active_o), 0);
    chk("post_rst_div", 32'(divisor_o), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
